// File: rtl/cr_prefix_attach_seq.sv
// cr_prefix_attach_seq: sequences PHD/PFD prefix fetch commands and reports per-request CRC completion status.
module cr_prefix_attach_seq #(
  parameter int N_PHD_WORDS = 65,
  parameter int N_PFD_WORDS = 128,
  parameter int CHK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [5:0] req_prefix_num,
  output logic       req_ready,
  input  logic       word_ready,
  output logic       ibp_prefix_valid,
  output logic [5:0] ibp_prefix_num,
  output logic       ibp_ld_phd_crc_addr,
  output logic       ibp_ld_pfd_crc_addr,
  output logic       ibp_inc_phd_addr,
  output logic       ibp_inc_pfd_addr,
  input  logic       pmc_pfd_crc_valid,
  input  logic       pmc_phd_check_valid,
  input  logic       pmc_pfd_check_valid,
  input  logic       pmc_phd_crc_error,
  input  logic       pmc_pfd_crc_error,
  output logic       done_valid,
  output logic [3:0] done_status
);
  typedef enum logic [2:0] {IDLE, LD_PHD, LD_PFD, WAIT_CRC, PHD_RUN, PFD_RUN, WAIT_CHK, DONE} state_t;
  localparam int TW = $clog2(CHK_TIMEOUT + 1);
  state_t state, next;
  logic [7:0] cnt;
  logic [TW-1:0] tcnt;
  logic phd_seen, pfd_seen, phd_err, pfd_err, timeout, bad_num;
  logic accept, phd_now, pfd_now, chk_done, chk_to, phd_last, pfd_last;
  assign req_ready           = state == IDLE;
  assign ibp_prefix_valid    = state != IDLE && state != DONE;
  assign ibp_ld_phd_crc_addr = state == LD_PHD;
  assign ibp_ld_pfd_crc_addr = state == LD_PFD;
  assign ibp_inc_phd_addr    = state == PHD_RUN && word_ready;
  assign ibp_inc_pfd_addr    = state == PFD_RUN && word_ready;
  assign done_valid          = state == DONE;
  assign done_status         = done_valid ? {timeout, bad_num, pfd_err, phd_err} : 4'd0;
  always_comb begin
    accept   = req_valid && state == IDLE;
    phd_now  = phd_seen || pmc_phd_check_valid;
    pfd_now  = pfd_seen || pmc_pfd_check_valid;
    chk_done = phd_now && pfd_now;
    chk_to   = tcnt == TW'(CHK_TIMEOUT - 1);
    phd_last = ibp_inc_phd_addr && cnt == 8'(N_PHD_WORDS - 1);
    pfd_last = ibp_inc_pfd_addr && cnt == 8'(N_PFD_WORDS - 1);
    next     = state;
    case (state)
      IDLE:     next = accept ? (req_prefix_num == 6'd0 ? DONE : LD_PHD) : IDLE;
      LD_PHD:   next = LD_PFD;
      LD_PFD:   next = WAIT_CRC;
      WAIT_CRC: next = pmc_pfd_crc_valid ? PHD_RUN : WAIT_CRC;
      PHD_RUN:  next = phd_last ? PFD_RUN : PHD_RUN;
      PFD_RUN:  next = pfd_last ? WAIT_CHK : PFD_RUN;
      WAIT_CHK: next = (chk_done || chk_to) ? DONE : WAIT_CHK;
      DONE:     next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ibp_prefix_num <= 6'd0;
      cnt            <= 8'd0;
      tcnt           <= '0;
      phd_seen       <= 1'b0;
      pfd_seen       <= 1'b0;
      phd_err        <= 1'b0;
      pfd_err        <= 1'b0;
      timeout        <= 1'b0;
      bad_num        <= 1'b0;
    end else begin
      state <= next;
      tcnt  <= state == WAIT_CHK ? tcnt + TW'(1) : '0;
      if (ibp_inc_phd_addr || ibp_inc_pfd_addr)
        cnt <= (phd_last || pfd_last) ? 8'd0 : cnt + 8'd1;
      if (accept) begin
        ibp_prefix_num <= req_prefix_num;
        bad_num        <= req_prefix_num == 6'd0;
        phd_seen       <= 1'b0;
        pfd_seen       <= 1'b0;
        phd_err        <= 1'b0;
        pfd_err        <= 1'b0;
        timeout        <= 1'b0;
      end
      // errors are latched only on the first cycle each check result is seen
      if (state == WAIT_CHK) begin
        phd_seen <= phd_now;
        pfd_seen <= pfd_now;
        if (pmc_phd_check_valid && !phd_seen) phd_err <= pmc_phd_crc_error;
        if (pmc_pfd_check_valid && !pfd_seen) pfd_err <= pmc_pfd_crc_error;
        if (chk_to && !chk_done) timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cr_prefix_attach_seq.sv
// tb_cr_prefix_attach_seq: directed checks of the prefix fetch sequencer against a small controller model.
module tb_cr_prefix_attach_seq;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, word_ready;
  logic [5:0] req_prefix_num, ibp_prefix_num;
  logic ibp_prefix_valid, ibp_ld_phd_crc_addr, ibp_ld_pfd_crc_addr, ibp_inc_phd_addr, ibp_inc_pfd_addr;
  logic pmc_pfd_crc_valid, pmc_phd_check_valid, pmc_pfd_check_valid, pmc_phd_crc_error, pmc_pfd_crc_error;
  logic done_valid;
  logic [3:0] done_status;
  int n_vec = 0, n_err = 0;
  int phd_dly = 0, pfd_dly = 0;
  logic phd_e = 1'b0, pfd_e = 1'b0;
  int since, pfd_n;
  logic d1;
  always #5 clk = ~clk;
  cr_prefix_attach_seq #(.N_PHD_WORDS(4), .N_PFD_WORDS(3), .CHK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_prefix_num(req_prefix_num), .req_ready(req_ready),
    .word_ready(word_ready), .ibp_prefix_valid(ibp_prefix_valid), .ibp_prefix_num(ibp_prefix_num),
    .ibp_ld_phd_crc_addr(ibp_ld_phd_crc_addr), .ibp_ld_pfd_crc_addr(ibp_ld_pfd_crc_addr),
    .ibp_inc_phd_addr(ibp_inc_phd_addr), .ibp_inc_pfd_addr(ibp_inc_pfd_addr),
    .pmc_pfd_crc_valid(pmc_pfd_crc_valid), .pmc_phd_check_valid(pmc_phd_check_valid),
    .pmc_pfd_check_valid(pmc_pfd_check_valid), .pmc_phd_crc_error(pmc_phd_crc_error),
    .pmc_pfd_crc_error(pmc_pfd_crc_error), .done_valid(done_valid), .done_status(done_status)
  );
  // controller model: CRC valid two cycles after the PFD load, checks a set delay after the last PFD word
  always @(posedge clk) begin
    if (rst || req_ready) begin
      d1 <= 1'b0;
      pmc_pfd_crc_valid <= 1'b0;
      since <= 0;
      pfd_n <= 0;
    end else begin
      d1 <= ibp_ld_pfd_crc_addr;
      pmc_pfd_crc_valid <= pmc_pfd_crc_valid | d1;
      if (ibp_inc_pfd_addr) begin
        pfd_n <= pfd_n + 1;
        if (pfd_n == 2) since <= 1;
      end else if (since != 0) since <= since + 1;
    end
  end
  assign pmc_phd_check_valid = phd_dly != 0 && since >= phd_dly;
  assign pmc_pfd_check_valid = pfd_dly != 0 && since >= pfd_dly;
  assign pmc_phd_crc_error   = pmc_phd_check_valid && phd_e;
  assign pmc_pfd_crc_error   = pmc_pfd_check_valid && pfd_e;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_req(input logic [5:0] num, input bit bp, input int pd, input int fd,
                         input logic pe, input logic fe, input int exp_done, input int exp_st,
                         input int p_first, input int p_last, input int f_first, input int f_last);
    bit bad = num == 6'd0;
    int ld_phd_at = 0, ld_pfd_at = 0, ld_n = 0, p_n = 0, f_n = 0, p_f = 0, p_l = 0, f_f = 0, f_l = 0;
    int stray = 0, pv = 0, pnum = -1, done_at = 0, st = -1;
    phd_dly = pd; pfd_dly = fd; phd_e = pe; pfd_e = fe;
    @(negedge clk);
    req_valid = 1'b1;
    req_prefix_num = num;
    #1 chk("req_ready_idle", int'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int rel = 1; rel <= 60 && done_at == 0; rel++) begin
      @(negedge clk);
      word_ready = bp ? (rel % 3 == 2) : 1'b1;
      #1;
      if (rel == 1) pnum = int'(ibp_prefix_num);
      if (ibp_ld_phd_crc_addr) begin ld_phd_at = rel; ld_n++; end
      if (ibp_ld_pfd_crc_addr) begin ld_pfd_at = rel; ld_n++; end
      if (ibp_ld_phd_crc_addr && ibp_ld_pfd_crc_addr) stray++;
      if ((ibp_inc_phd_addr || ibp_inc_pfd_addr) && !word_ready) stray++;
      if (ibp_inc_phd_addr) begin p_n++; p_l = rel; if (p_f == 0) p_f = rel; end
      if (ibp_inc_pfd_addr) begin f_n++; f_l = rel; if (f_f == 0) f_f = rel; end
      if (ibp_prefix_valid) pv = 1;
      if (done_valid) begin done_at = rel; st = int'(done_status); end
    end
    chk($sformatf("p%0d_prefix_num", num), pnum, int'(num));
    chk($sformatf("p%0d_done_at", num), done_at, exp_done);
    chk($sformatf("p%0d_status", num), st, exp_st);
    chk($sformatf("p%0d_ld_phd_at", num), ld_phd_at, bad ? 0 : 1);
    chk($sformatf("p%0d_ld_pfd_at", num), ld_pfd_at, bad ? 0 : 2);
    chk($sformatf("p%0d_ld_count", num), ld_n, bad ? 0 : 2);
    chk($sformatf("p%0d_phd_incs", num), p_n, bad ? 0 : 4);
    chk($sformatf("p%0d_pfd_incs", num), f_n, bad ? 0 : 3);
    chk($sformatf("p%0d_phd_span", num), p_f * 100 + p_l, p_first * 100 + p_last);
    chk($sformatf("p%0d_pfd_span", num), f_f * 100 + f_l, f_first * 100 + f_last);
    chk($sformatf("p%0d_stray", num), stray, 0);
    chk($sformatf("p%0d_prefix_valid", num), pv, bad ? 0 : 1);
    @(negedge clk);
    #1 chk($sformatf("p%0d_ready_after", num), int'(req_ready), 1);
    chk($sformatf("p%0d_done_single", num), int'(done_valid), 0);
  endtask
  initial begin
    int dseen;
    rst = 1'b1; req_valid = 1'b0; req_prefix_num = 6'd0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_outs", int'({ibp_prefix_valid, ibp_ld_phd_crc_addr, ibp_ld_pfd_crc_addr,
                          ibp_inc_phd_addr, ibp_inc_pfd_addr, done_valid}), 0);
    chk("rst_prefix_num", int'(ibp_prefix_num), 0);
    chk("rst_status", int'(done_status), 0);
    rst = 1'b0;
    run_req(6'd5, 1'b0, 3, 3, 1'b0, 1'b0, 15, 4'b0000, 5, 8, 9, 11);
    run_req(6'd12, 1'b1, 3, 3, 1'b0, 1'b0, 27, 4'b0000, 5, 14, 17, 23);
    run_req(6'd33, 1'b0, 3, 5, 1'b1, 1'b0, 17, 4'b0001, 5, 8, 9, 11);
    run_req(6'd34, 1'b0, 3, 5, 1'b0, 1'b1, 17, 4'b0010, 5, 8, 9, 11);
    run_req(6'd0, 1'b0, 3, 3, 1'b0, 1'b0, 1, 4'b0100, 0, 0, 0, 0);
    run_req(6'd63, 1'b0, 3, 0, 1'b1, 1'b0, 28, 4'b1001, 5, 8, 9, 11);
    // reset in PHD_RUN after two increments (cycles T+5, T+6)
    phd_dly = 3; pfd_dly = 3; phd_e = 1'b0; pfd_e = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_prefix_num = 6'd9; word_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_ibp", int'({ibp_prefix_valid, ibp_ld_phd_crc_addr, ibp_ld_pfd_crc_addr,
                             ibp_inc_phd_addr, ibp_inc_pfd_addr}), 0);
    chk("mid_rst_ready", int'(req_ready), 1);
    dseen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_valid) dseen = 1;
      @(negedge clk);
      #1;
    end
    chk("mid_rst_no_done", dseen, 0);
    run_req(6'd7, 1'b0, 3, 3, 1'b0, 1'b0, 15, 4'b0000, 5, 8, 9, 11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cr_prefix_attach_seq.md
# cr_prefix_attach_seq

Prefix fetch sequencer for the prefix-attach path. It accepts one prefix request at a time and drives the PHD/PFD memory controller's command inputs (the `ibp_*` signals) in a fixed order: CRC-address loads, then paced PHD word increments, then PFD word increments. It then collects the controller's CRC check results and reports a single completion status per request. It sits directly upstream of the prefix memory controller and is the sole source of its `ibp_*` inputs.

## Interface
Parameters:
- `N_PHD_WORDS`, 65: PHD words fetched per prefix (1..127).
- `N_PFD_WORDS`, 128: PFD words fetched per prefix (1..128).
- `CHK_TIMEOUT`, 1024: maximum cycles to wait in WAIT_CHK (≥4).

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  prefix request valid.
- `req_prefix_num`  in  6  prefix number; 0 is illegal.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `word_ready`  in  1  downstream may take one more word this cycle.
- `ibp_prefix_valid`  out  1  memory chip-select enable.
- `ibp_prefix_num`  out  6  latched prefix number.
- `ibp_ld_phd_crc_addr`  out  1  one-cycle PHD CRC load.
- `ibp_ld_pfd_crc_addr`  out  1  one-cycle PFD CRC load.
- `ibp_inc_phd_addr`  out  1  PHD word advance.
- `ibp_inc_pfd_addr`  out  1  PFD word advance.
- `pmc_pfd_crc_valid`  in  1  controller has captured the PFD CRC.
- `pmc_phd_check_valid`, `pmc_pfd_check_valid`  in  1 each  check results valid (held until acked elsewhere).
- `pmc_phd_crc_error`, `pmc_pfd_crc_error`  in  1 each  CRC mismatch, qualified by the matching check_valid.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_status`  out  4  {timeout, bad_num, pfd_err, phd_err}, valid with `done_valid`.

## Operation
- States: IDLE, LD_PHD, LD_PFD, WAIT_CRC, PHD_RUN, PFD_RUN, WAIT_CHK, DONE.
- IDLE:
  - `req_ready=1`.
  - On accept, latch `req_prefix_num` into `ibp_prefix_num` and clear the status flags.
  - Prefix number 0: go to DONE with `bad_num=1`. No `ibp_*` pulse and no memory access.
  - Otherwise go to LD_PHD.
- LD_PHD: `ibp_ld_phd_crc_addr=1` for one cycle, then LD_PFD.
- LD_PFD: `ibp_ld_pfd_crc_addr=1` for one cycle, then WAIT_CRC. The two loads are never asserted together.
- WAIT_CRC: hold until `pmc_pfd_crc_valid=1`, then go to PHD_RUN.
- PHD_RUN:
  - `ibp_inc_phd_addr = word_ready`.
  - An 8-bit word counter increments on each issued increment.
  - After the `N_PHD_WORDS`-th increment, clear the counter and go to PFD_RUN.
- PFD_RUN: same pacing on `ibp_inc_pfd_addr` for `N_PFD_WORDS` increments, then WAIT_CHK.
- WAIT_CHK:
  - Sticky flags `phd_seen` and `pfd_seen` set on the respective check_valid.
  - `phd_err`/`pfd_err` capture the matching crc_error in the cycle each check_valid is first seen.
  - When both seen flags are set, go to DONE.
  - A timeout counter clears on entry and increments each cycle. At `CHK_TIMEOUT` it forces DONE with `timeout=1`. Errors already captured are kept.
- DONE: `done_valid=1` for one cycle, then IDLE.
- `ibp_prefix_valid=1` in every state except IDLE and DONE.
- Increments are never issued outside PHD_RUN/PFD_RUN. `word_ready` is ignored in all other states.

## Timing
- Reset values:
  - All outputs 0 except `req_ready=1`.
  - `ibp_prefix_num=0`, `done_status=0`, state IDLE.
  - Counters and flags 0.
- A reset asserted mid-sequence aborts immediately: no `done_valid` is issued, and the next cycle is IDLE.
- Accept at cycle T:
  - `ibp_ld_phd_crc_addr` at T+1.
  - `ibp_ld_pfd_crc_addr` at T+2.
  - `pmc_pfd_crc_valid` expected at T+4.
  - First `ibp_inc_phd_addr` no earlier than T+5.
- With `word_ready` held high, PHD increments occupy T+5 .. T+4+N_PHD_WORDS and PFD increments follow back-to-back with no bubble.
- `word_ready` low stalls the sequence without losing count. Increments equal exactly the number of `word_ready`-high cycles within the run states.
- If both check_valid signals rise in the same cycle, both are captured and the next state is DONE.
- A check_valid already high on WAIT_CHK entry counts as seen in that entry cycle.
- Bad-number path: accept at T, `done_valid` at T+1.
- `done_status` is valid only while `done_valid=1`.
- `req_ready` returns high the cycle after DONE.

## Test plan
Bench parameters: `N_PHD_WORDS=4`, `N_PFD_WORDS=3`, `CHK_TIMEOUT=16`.

- Basic pass:
  - Stimulus: request prefix 5 with `word_ready=1`; model the controller so `pmc_pfd_crc_valid` rises at T+4 and both check_valid signals rise 3 cycles after the last PFD increment, errors 0.
  - Required response: lds at T+1/T+2; PHD increments T+5..T+8; PFD increments T+9..T+11; `done_status=0000`; `ibp_prefix_num=5`.
- Backpressure:
  - Stimulus: toggle `word_ready` 1,0,0,1,...
  - Required response: exactly 4 PHD and 3 PFD increments, each coinciding with `word_ready=1`; final status 0000.
- CRC errors:
  - Stimulus: PHD check with error=1, PFD check 2 cycles later with error=0.
  - Required response: `done_status=0001`.
  - Repeat with the PFD error only: `done_status=0010`.
- Illegal prefix:
  - Stimulus: `req_prefix_num=0`.
  - Required response: no `ibp_*` pulses, `ibp_prefix_valid` stays 0, `done_valid` at T+1 with `done_status=0100`.
- Timeout:
  - Stimulus: only PHD check_valid returned, with error=1.
  - Required response: `done_valid` 16 cycles after WAIT_CHK entry with `done_status=1001`.
- Reset mid-run:
  - Stimulus: assert `rst` during PHD_RUN after 2 increments.
  - Required response: next cycle all `ibp_*` outputs 0, `req_ready=1`, no `done_valid`; a new request for prefix 7 then completes normally with status 0000.
